// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master's control FSM states.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_ERR,
      ST_FLUSH
   } fsm_e;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands in, single pipelined
// transfers out, one in-order response per command.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [2:0]            cmd_size,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [DATA_WIDTH-1:0] HWDATA,
   input  logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   fsm_e                  fsm_q, fsm_d;
   logic                  cancel_q, cancel_d;

   logic                  ap_valid_q, ap_valid_d;
   logic                  ap_write_q, ap_write_d;
   logic [ADDR_WIDTH-1:0] ap_addr_q, ap_addr_d;
   logic [2:0]            ap_size_q, ap_size_d;
   logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;

   logic                  dp_valid_q, dp_valid_d;
   logic                  dp_write_q, dp_write_d;
   logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;

   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_error_q, rsp_error_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         fsm_q       <= ST_RUN;
         cancel_q    <= 1'b0;
         ap_valid_q  <= 1'b0;
         ap_write_q  <= 1'b0;
         ap_addr_q   <= '0;
         ap_size_q   <= HSIZE_WORD;
         ap_wdata_q  <= '0;
         dp_valid_q  <= 1'b0;
         dp_write_q  <= 1'b0;
         dp_wdata_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         fsm_q       <= fsm_d;
         cancel_q    <= cancel_d;
         ap_valid_q  <= ap_valid_d;
         ap_write_q  <= ap_write_d;
         ap_addr_q   <= ap_addr_d;
         ap_size_q   <= ap_size_d;
         ap_wdata_q  <= ap_wdata_d;
         dp_valid_q  <= dp_valid_d;
         dp_write_q  <= dp_write_d;
         dp_wdata_q  <= dp_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      cancel_d    = cancel_q;
      ap_valid_d  = ap_valid_q;
      ap_write_d  = ap_write_q;
      ap_addr_d   = ap_addr_q;
      ap_size_d   = ap_size_q;
      ap_wdata_d  = ap_wdata_q;
      dp_valid_d  = dp_valid_q;
      dp_write_d  = dp_write_q;
      dp_wdata_d  = dp_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = '0;

      unique case (fsm_q)
         ST_RUN: begin
            if (HREADY) begin
               if (dp_valid_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_error_d = HRESP;
                  if (!dp_write_q && HRESP == HRESP_OKAY)
                     rsp_rdata_d = HRDATA;
               end
               dp_valid_d = ap_valid_q;
               dp_write_d = ap_write_q;
               dp_wdata_d = ap_wdata_q;
               ap_valid_d = cmd_valid;
               if (cmd_valid) begin
                  ap_write_d = cmd_write;
                  ap_addr_d  = cmd_addr;
                  ap_size_d  = cmd_size;
                  ap_wdata_d = cmd_wdata;
               end
            end else if (HRESP == HRESP_ERROR && dp_valid_q) begin
               // first error cycle: pull the queued address phase
               fsm_d      = ST_ERR;
               ap_valid_d = 1'b0;
               cancel_d   = ap_valid_q;
            end
         end
         ST_ERR: begin
            if (HREADY) begin
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               dp_valid_d  = 1'b0;
               fsm_d       = cancel_q ? ST_FLUSH : ST_RUN;
            end
         end
         ST_FLUSH: begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            cancel_d    = 1'b0;
            fsm_d       = ST_RUN;
         end
         default: begin
            fsm_d = ST_RUN;
         end
      endcase
   end

   assign cmd_ready = HREADY && (fsm_q == ST_RUN);

   assign HADDR  = ap_addr_q;
   assign HTRANS = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HWRITE = ap_write_q;
   assign HSIZE  = ap_size_q;
   assign HBURST = HBURST_SINGLE;
   assign HWDATA = dp_wdata_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_error = rsp_error_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: per-cycle vector table plus a response
// scoreboard fed at command acceptance.
module tb_ahb_lite_master;

   logic        CLK;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int total = 0;
   int bad   = 0;

   ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      if (a == 32'h8) return 32'h0000_00C3;
      return {a[15:0], 16'hBEEF} ^ 32'h1234_0000;
   endfunction

   // slave model: read data follows the address captured on HREADY
   logic [31:0] dph_addr;
   always @(posedge CLK or negedge RST) begin
      if (!RST) dph_addr <= '0;
      else if (HREADY) dph_addr <= HADDR;
   end
   assign HRDATA = rd_fn(dph_addr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t sb[$];
   logic exp_err;

   always @(posedge CLK) begin
      if (RST && cmd_valid && cmd_ready) begin
         rsp_t r;
         r.err  = exp_err;
         r.data = (cmd_write || exp_err) ? 32'h0 : rd_fn(cmd_addr);
         sb.push_back(r);
      end
   end

   always @(negedge CLK) begin
      if (RST && rsp_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected actual=1 required=0");
         end else begin
            rsp_t r;
            r = sb.pop_front();
            chk("rsp_error", {31'b0, rsp_error}, {31'b0, r.err});
            chk("rsp_rdata", rsp_rdata, r.data);
         end
      end
   end

   typedef struct {
      logic        cv;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        hr;
      logic        hresp;
      logic        eerr;
      logic [1:0]  e_tr;
      logic [31:0] e_addr;
      logic        e_wr;
      logic        e_rdy;
      logic        chk_wd;
      logic [31:0] e_wd;
   } vec_t;

   function automatic vec_t v(
      input logic cv, input logic wr, input logic [31:0] addr,
      input logic [31:0] wd, input logic hr, input logic hresp,
      input logic eerr, input logic [1:0] e_tr,
      input logic [31:0] e_addr, input logic e_wr, input logic e_rdy,
      input logic chk_wd, input logic [31:0] e_wd);
      vec_t t;
      t.cv = cv; t.wr = wr; t.addr = addr; t.wd = wd;
      t.hr = hr; t.hresp = hresp; t.eerr = eerr;
      t.e_tr = e_tr; t.e_addr = e_addr; t.e_wr = e_wr;
      t.e_rdy = e_rdy; t.chk_wd = chk_wd; t.e_wd = e_wd;
      return t;
   endfunction

   vec_t vecs[$];

   initial begin
      // single write
      vecs.push_back(v(1,1,32'h4,32'hA5A5_1234,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 2,32'h4,1,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 1,32'hA5A5_1234));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      // single read
      vecs.push_back(v(1,0,32'h8,0,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 2,32'h8,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      // back-to-back W/R/W
      vecs.push_back(v(1,1,32'h0,32'h1111_1111,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(1,0,32'h4,0,1,0,0, 2,32'h0,1,1, 0,0));
      vecs.push_back(v(1,1,32'h8,32'h2222_2222,1,0,0,
                       2,32'h4,0,1, 1,32'h1111_1111));
      vecs.push_back(v(0,0,0,0,1,0,0, 2,32'h8,1,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 1,32'h2222_2222));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      // read with two wait states, write queued behind it
      vecs.push_back(v(1,0,32'h14,0,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(1,1,32'h18,32'h3333_3333,1,0,0,
                       2,32'h14,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,0,0,0, 2,32'h18,1,0, 0,0));
      vecs.push_back(v(0,0,0,0,0,0,0, 2,32'h18,1,0, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 2,32'h18,1,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 1,32'h3333_3333));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      // write error with a read cancelled in the address phase
      vecs.push_back(v(1,1,32'hC,32'h4444_4444,1,0,1, 0,0,0,1, 0,0));
      vecs.push_back(v(1,0,32'h10,0,1,0,1, 2,32'hC,1,1, 0,0));
      vecs.push_back(v(0,0,0,0,0,1,0, 2,32'h10,0,0, 0,0));
      vecs.push_back(v(0,0,0,0,1,1,0, 0,0,0,0, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,0, 0,0));
      vecs.push_back(v(1,1,32'h20,32'h5555_5555,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 2,32'h20,1,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 1,32'h5555_5555));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));
      vecs.push_back(v(0,0,0,0,1,0,0, 0,0,0,1, 0,0));

      RST = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_size  = 3'b010;
      cmd_wdata = '0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
      exp_err   = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", {31'b0, HWRITE}, 32'h0);
      chk("rst_hsize", {29'b0, HSIZE}, 32'h2);
      chk("rst_hburst", {29'b0, HBURST}, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
      RST = 1'b1;

      foreach (vecs[i]) begin
         @(negedge CLK);
         cmd_valid = vecs[i].cv;
         cmd_write = vecs[i].wr;
         cmd_addr  = vecs[i].addr;
         cmd_wdata = vecs[i].wd;
         HREADY    = vecs[i].hr;
         HRESP     = vecs[i].hresp;
         exp_err   = vecs[i].eerr;
         #1;
         chk($sformatf("v%0d_htrans", i), {30'b0, HTRANS},
             {30'b0, vecs[i].e_tr});
         chk($sformatf("v%0d_cmd_ready", i), {31'b0, cmd_ready},
             {31'b0, vecs[i].e_rdy});
         chk($sformatf("v%0d_hburst", i), {29'b0, HBURST}, 32'h0);
         if (vecs[i].e_tr == 2'b10) begin
            chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].e_addr);
            chk($sformatf("v%0d_hwrite", i), {31'b0, HWRITE},
                {31'b0, vecs[i].e_wr});
         end
         if (vecs[i].chk_wd)
            chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].e_wd);
      end
      chk("sb_drained", sb.size(), 32'h0);

      // reset asserted during a wait-stated read
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
      HREADY = 1'b1; HRESP = 1'b0; exp_err = 1'b0;
      @(negedge CLK);
      cmd_valid = 1'b0;
      #1 chk("rr_htrans", {30'b0, HTRANS}, 32'h2);
      @(negedge CLK);
      HREADY = 1'b0;
      @(negedge CLK);
      #1 chk("rr_wait_ready", {31'b0, cmd_ready}, 32'h0);
      #2 RST = 1'b0;
      #1;
      chk("rr_async_htrans", {30'b0, HTRANS}, 32'h0);
      chk("rr_async_rsp", {31'b0, rsp_valid}, 32'h0);
      chk("rr_async_haddr", HADDR, 32'h0);
      sb.delete();
      @(negedge CLK);
      RST = 1'b1;
      HREADY = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h28;
      cmd_wdata = 32'h6666_6666;
      #1 chk("rr_post_ready", {31'b0, cmd_ready}, 32'h1);
      @(negedge CLK);
      cmd_valid = 1'b0;
      #1;
      chk("rr_post_htrans", {30'b0, HTRANS}, 32'h2);
      chk("rr_post_haddr", HADDR, 32'h28);
      @(negedge CLK);
      #1 chk("rr_post_hwdata", HWDATA, 32'h6666_6666);
      repeat (3) @(negedge CLK);
      #1 chk("sb_final", sb.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
